// File: rtl/lcd_timebase_pkg.sv
// Shared constants, types and helpers for the LCD timebase.
package lcd_timebase_pkg;

  // Smallest divisor that still gives a distinct low and high phase.
  localparam int MIN_DIV     = 2;
  localparam int DEFAULT_DIV = 6;

  // Delay timer states.
  typedef enum logic {
    DLY_IDLE = 1'b0,
    DLY_BUSY = 1'b1
  } dly_state_t;

  // Divisors of 0 or 1 cannot produce a square wave, so they become MIN_DIV.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    if (v < 32'(MIN_DIV)) begin
      return 32'(MIN_DIV);
    end
    return v;
  endfunction

endpackage

// File: rtl/lcd_tick_div.sv
// Runtime-programmable clock-enable divider: period counter, shadow/active
// divisor with wrap-aligned update, one-cycle tick and square-wave clk_out.
module lcd_tick_div #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic                 div_load,
  output logic                 div_pending,
  output logic                 tick,
  output logic                 clk_out,
  output logic                 wrap
);
  import lcd_timebase_pkg::*;

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] active_div;
  logic [DIV_WIDTH-1:0] shadow_div;
  logic [DIV_WIDTH-1:0] div_clamped;

  assign div_clamped = DIV_WIDTH'(clamp_div(32'(div_val)));

  // Last count of the period; only meaningful while the divider runs.
  assign wrap = en && (cnt == (active_div - ONE));

  // Period counter plus registered tick and square wave; all frozen when en=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (en) begin
      cnt     <= wrap ? '0 : cnt + ONE;
      tick    <= wrap;
      clk_out <= (cnt >= (active_div >> 1));
    end else begin
      tick    <= 1'b0;
    end
  end

  // A new divisor waits in the shadow until the current period completes;
  // a load on the wrap cycle itself takes priority and waits one more period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_div  <= DIV_WIDTH'(DEFAULT_DIV);
      shadow_div  <= DIV_WIDTH'(DEFAULT_DIV);
      div_pending <= 1'b0;
    end else if (div_load) begin
      shadow_div  <= div_clamped;
      div_pending <= 1'b1;
    end else if (wrap && div_pending) begin
      active_div  <= shadow_div;
      div_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_timebase.sv
// HD44780 timebase: programmable tick divider plus a one-shot delay timer
// that counts divider ticks for power-on and command execution waits.
module lcd_timebase #(
  parameter int DIV_WIDTH   = 16,
  parameter int DELAY_WIDTH = 20,
  parameter int DEFAULT_DIV = lcd_timebase_pkg::DEFAULT_DIV
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DIV_WIDTH-1:0]   div_val,
  input  logic                   div_load,
  output logic                   div_pending,
  output logic                   tick,
  output logic                   clk_out,
  input  logic                   delay_start,
  input  logic [DELAY_WIDTH-1:0] delay_cycles,
  output logic                   delay_busy,
  output logic                   delay_done
);
  import lcd_timebase_pkg::*;

  localparam logic [DELAY_WIDTH-1:0] DONE_AT = DELAY_WIDTH'(1);

  logic                   wrap;
  dly_state_t             state;
  dly_state_t             state_nx;
  logic [DELAY_WIDTH-1:0] remaining;
  logic [DELAY_WIDTH-1:0] remaining_nx;
  logic                   done_nx;

  lcd_tick_div #(
    .DIV_WIDTH   (DIV_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .div_val     (div_val),
    .div_load    (div_load),
    .div_pending (div_pending),
    .tick        (tick),
    .clk_out     (clk_out),
    .wrap        (wrap)
  );

  assign delay_busy = (state == DLY_BUSY);

  // Delay next state: starts only from idle, counts down on wraps, and
  // raises done on the same edge that registers the final tick.
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    done_nx      = 1'b0;
    case (state)
      DLY_IDLE: begin
        if (delay_start) begin
          if (delay_cycles == '0) begin
            done_nx = 1'b1;
          end else begin
            remaining_nx = delay_cycles;
            state_nx     = DLY_BUSY;
          end
        end
      end
      DLY_BUSY: begin
        if (wrap) begin
          if (remaining == DONE_AT) begin
            done_nx      = 1'b1;
            remaining_nx = '0;
            state_nx     = DLY_IDLE;
          end else begin
            remaining_nx = remaining - DONE_AT;
          end
        end
      end
      default: begin
        state_nx     = DLY_IDLE;
        remaining_nx = '0;
      end
    endcase
  end

  // Delay state, countdown and done pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= DLY_IDLE;
      remaining  <= '0;
      delay_done <= 1'b0;
    end else begin
      state      <= state_nx;
      remaining  <= remaining_nx;
      delay_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_lcd_timebase.sv
// Directed and randomized bench for lcd_timebase against a cycle model kept
// as plain integers (phase, divisor, ticks-to-go).
module tb_lcd_timebase;
  localparam int DW = 16;
  localparam int LW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] div_val;
  logic          div_load;
  logic          div_pending;
  logic          tick;
  logic          clk_out;
  logic          delay_start;
  logic [LW-1:0] delay_cycles;
  logic          delay_busy;
  logic          delay_done;

  lcd_timebase #(.DIV_WIDTH(DW), .DELAY_WIDTH(LW), .DEFAULT_DIV(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .div_val      (div_val),
    .div_load     (div_load),
    .div_pending  (div_pending),
    .tick         (tick),
    .clk_out      (clk_out),
    .delay_start  (delay_start),
    .delay_cycles (delay_cycles),
    .delay_busy   (delay_busy),
    .delay_done   (delay_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int tick_log[$];
  int done_log[$];

  // Reference model state
  int m_phase, m_n, m_shadow, m_pend, m_tick, m_clk, m_busy, m_togo, m_done;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_n = 6; m_shadow = 6; m_pend = 0;
    m_tick = 0; m_clk = 0; m_busy = 0; m_togo = 0; m_done = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit last;
    last = (en === 1'b1) && (m_phase == m_n - 1);
    if (en === 1'b1) begin
      m_tick  = last;
      m_clk   = (2 * m_phase >= (m_n - (m_n % 2))) ? 1 : 0;
      m_phase = last ? 0 : m_phase + 1;
    end else begin
      m_tick = 0;
    end
    if (div_load === 1'b1) begin
      m_shadow = (int'(div_val) < 2) ? 2 : int'(div_val);
      m_pend   = 1;
    end else if (last && m_pend == 1) begin
      m_n    = m_shadow;
      m_pend = 0;
    end
    m_done = 0;
    if (m_busy == 0) begin
      if (delay_start === 1'b1) begin
        if (delay_cycles == 0) m_done = 1;
        else begin
          m_togo = int'(delay_cycles);
          m_busy = 1;
        end
      end
    end else if (last) begin
      m_togo--;
      if (m_togo == 0) begin
        m_done = 1;
        m_busy = 0;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check("tick", tick, m_tick[0]);
    check("clk_out", clk_out, m_clk[0]);
    check("div_pending", div_pending, m_pend[0]);
    check("delay_busy", delay_busy, m_busy[0]);
    check("delay_done", delay_done, m_done[0]);
    if (tick === 1'b1) tick_log.push_back(cyc);
    if (delay_done === 1'b1) done_log.push_back(cyc);
    div_load    = 1'b0;
    delay_start = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Assert reset mid-cycle, check the cleared outputs, release on a falling edge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_tick", tick, 1'b0);
    check("rst_clk_out", clk_out, 1'b0);
    check("rst_pending", div_pending, 1'b0);
    check("rst_busy", delay_busy, 1'b0);
    check("rst_done", delay_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    tick_log.delete();
    done_log.delete();
  endtask

  initial begin
    int start_cyc;
    rst = 1'b0; en = 1'b1; div_val = '0; div_load = 1'b0;
    delay_start = 1'b0; delay_cycles = '0;
    do_reset();

    // Default divisor 6, then load 4 before the 8th edge
    for (int i = 0; i < 24; i++) begin
      if (cyc == 7) begin
        div_val  = 16'd4;
        div_load = 1'b1;
      end
      cycle();
    end
    check_int("tick_count_a", tick_log.size(), 5);
    check_int("tick0", tick_log[0], 6);
    check_int("tick1", tick_log[1], 12);
    check_int("tick2", tick_log[2], 16);
    check_int("tick4", tick_log[4], 24);

    // Clamp: div_val=1 behaves as 2, then odd divisor 7
    div_val = 16'd1; div_load = 1'b1;
    run(14);
    div_val = 16'd7; div_load = 1'b1;
    run(24);

    // Back to N=4 and a K=3 delay; second start while busy is ignored
    div_val = 16'd4; div_load = 1'b1;
    run(10);
    tick_log.delete(); done_log.delete();
    delay_cycles = 20'd3; delay_start = 1'b1;
    cycle();
    start_cyc = cyc;
    check("busy_after_start", delay_busy, 1'b1);
    run(2);
    delay_cycles = 20'd9; delay_start = 1'b1;
    run(16);
    check_int("done_count", done_log.size(), 1);
    check_int("done_on_3rd_tick", done_log[0], tick_log[2]);
    check("done_after_start", logic'(done_log[0] > start_cyc), 1'b1);

    // K=0: done next cycle, busy never set
    delay_cycles = 20'd0; delay_start = 1'b1;
    cycle();
    check("k0_done", delay_done, 1'b1);
    check("k0_busy", delay_busy, 1'b0);
    run(2);

    // Freeze mid-delay, resume, then reset mid-delay
    delay_cycles = 20'd5; delay_start = 1'b1;
    run(6);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(5);
    do_reset();
    run(7);
    check_int("post_rst_first_tick", tick_log[0], 6);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 11) == 0) begin
        div_val  = DW'($urandom_range(0, 9));
        div_load = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) begin
        delay_cycles = LW'($urandom_range(0, 4));
        delay_start  = 1'b1;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
